// File: rtl/pht_update_ctrl.sv
// pht_update_ctrl: 2-bit PHT with an in-order in-flight queue.
// Define PHT_BYPASS_EN to forward same-cycle training to lookups.
module pht_update_ctrl #(
  parameter int INDEX_W = 4,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pred_req,
  input  logic [INDEX_W-1:0] pred_idx,
  output logic               pred_ready,
  output logic               pred_valid,
  output logic               pred_taken,
  input  logic               resolve_valid,
  input  logic               resolve_taken,
  input  logic               flush,
  output logic               mispredict,
  output logic               resolve_err
);

  localparam int ENTRIES = 1 << INDEX_W;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [1:0]         cnt_q [ENTRIES];
  logic [INDEX_W-1:0] qidx_q [DEPTH];
  logic [DEPTH-1:0]   qpred_q;

  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [CW-1:0] occ_q, occ_d;

  logic pred_valid_q, pred_taken_q;
  logic misp_q, err_q;

  logic               full, empty;
  logic               accept, pop;
  logic [INDEX_W-1:0] head_idx;
  logic               head_pred;
  logic [1:0]         head_cnt;
  logic [1:0]         train_val;
  logic               pred_bit;

  assign full       = (occ_q == CW'(DEPTH));
  assign empty      = (occ_q == '0);
  assign pred_ready = !full && !flush;
  assign accept     = pred_req && pred_ready;
  assign pop        = resolve_valid && !empty;

  assign head_idx  = qidx_q[rd_q];
  assign head_pred = qpred_q[rd_q];
  assign head_cnt  = cnt_q[head_idx];

  // Saturating update of the head entry's counter.
  always_comb begin
    train_val = head_cnt;
    unique case (1'b1)
      resolve_taken && (head_cnt != 2'b11):
        train_val = head_cnt + 2'd1;
      !resolve_taken && (head_cnt != 2'b00):
        train_val = head_cnt - 2'd1;
      default: train_val = head_cnt;
    endcase
  end

  // Direction for the incoming request.
  always_comb begin
`ifdef PHT_BYPASS_EN
    if (pop && (head_idx == pred_idx))
      pred_bit = train_val[1];
    else
      pred_bit = cnt_q[pred_idx][1];
`else
    pred_bit = cnt_q[pred_idx][1];
`endif
  end

  // Queue pointers; flush empties after the same-cycle pop.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    occ_d = occ_q + CW'(accept) - CW'(pop);
    if (accept) wr_d = wr_q + PW'(1);
    if (pop)    rd_d = rd_q + PW'(1);
    if (flush) begin
      rd_d  = wr_q;
      occ_d = '0;
    end
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  // Counter table: reset to weakly not-taken, train on pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++)
        cnt_q[i] <= 2'b01;
    end else if (pop) begin
      cnt_q[head_idx] <= train_val;
    end
  end

  // Queue payload written on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        qidx_q[i] <= '0;
      qpred_q <= '0;
    end else if (accept) begin
      qidx_q[wr_q]  <= pred_idx;
      qpred_q[wr_q] <= pred_bit;
    end
  end

  // Registered response and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      misp_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      pred_valid_q <= accept;
      pred_taken_q <= accept && pred_bit;
      misp_q       <= pop && (resolve_taken ^ head_pred);
      err_q        <= err_q || (resolve_valid && empty);
    end
  end

  assign pred_valid  = pred_valid_q;
  assign pred_taken  = pred_taken_q;
  assign mispredict  = misp_q;
  assign resolve_err = err_q;

endmodule

// File: tb/tb_pht_update_ctrl.sv
// tb_pht_update_ctrl: directed + random checks of pht_update_ctrl
// against a queue/array reference model.
module tb_pht_update_ctrl;

  localparam int IW = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pred_req = 1'b0;
  logic [IW-1:0] pred_idx = '0;
  logic pred_ready, pred_valid, pred_taken;
  logic resolve_valid = 1'b0;
  logic resolve_taken = 1'b0;
  logic flush = 1'b0;
  logic mispredict, resolve_err;

  int checks = 0;
  int failures = 0;

  pht_update_ctrl #(.INDEX_W(IW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .pred_req(pred_req), .pred_idx(pred_idx),
    .pred_ready(pred_ready), .pred_valid(pred_valid),
    .pred_taken(pred_taken),
    .resolve_valid(resolve_valid),
    .resolve_taken(resolve_taken),
    .flush(flush), .mispredict(mispredict),
    .resolve_err(resolve_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    bit pred;
  } ent_t;

  int   mctr [16];
  ent_t mq[$];
  bit   merr;
  bit   exp_ready, exp_valid, exp_taken, exp_misp;
  logic obs_ready;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mctr[i] = 1;
    mq.delete();
    merr = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // One clock: drive inputs, advance model, sample ready.
  task automatic cycle(input bit req, input int idx,
                       input bit rv, input bit rt,
                       input bit fl);
    int   pre, val;
    bit   acc;
    ent_t e;
    pred_req      = req;
    pred_idx      = IW'(idx);
    resolve_valid = rv;
    resolve_taken = rt;
    flush         = fl;
    exp_ready = (mq.size() < DEPTH) && !fl;
    acc = req && exp_ready;
    pre = mctr[idx];
    exp_misp = 0;
    if (rv && mq.size() > 0) begin
      e = mq.pop_front();
      exp_misp = (rt != e.pred);
      if (rt) mctr[e.idx] = (mctr[e.idx] >= 3) ? 3 : mctr[e.idx] + 1;
      else    mctr[e.idx] = (mctr[e.idx] <= 0) ? 0 : mctr[e.idx] - 1;
    end else if (rv) begin
      merr = 1;
    end
    val = pre;
`ifdef PHT_BYPASS_EN
    val = mctr[idx];
`endif
    exp_valid = acc;
    exp_taken = acc && (val >= 2);
    if (acc) begin
      e.idx = idx;
      e.pred = (val >= 2);
      mq.push_back(e);
    end
    if (fl) mq.delete();
    #2 obs_ready = pred_ready;
    @(posedge clk);
    #1;
    pred_req = 0; resolve_valid = 0;
    resolve_taken = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #3;
    checks++;
    if ({pred_valid, pred_taken, mispredict, resolve_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_outs got=%b exp=0000",
               {pred_valid, pred_taken, mispredict, resolve_err});
    end
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", pred_ready);
    end
  endtask

  task automatic test_basic();
    cycle(1, 3, 0, 0, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== 1'b0) begin
      failures++;
      $display("FAIL basic_pred got=%b%b exp=10",
               pred_valid, pred_taken);
    end
    checks++;
    if (dut.cnt_q[3] !== 2'b01) begin
      failures++;
      $display("FAIL basic_cnt got=%b exp=01", dut.cnt_q[3]);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (pred_valid !== 1'b0 || mispredict !== exp_misp) begin
      failures++;
      $display("FAIL basic_idle got=%b%b exp=0%b",
               pred_valid, mispredict, exp_misp);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] want [3];
    want[0] = 2'b10; want[1] = 2'b11; want[2] = 2'b11;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cycle(1, 5, 0, 0, 0);
      checks++;
      if (pred_valid !== 1'b1 || pred_taken !== exp_taken) begin
        failures++;
        $display("FAIL sat_pred%0d got=%b%b exp=1%b", k,
                 pred_valid, pred_taken, exp_taken);
      end
      if (k == 2) begin
        checks++;
        if (pred_taken !== 1'b1) begin
          failures++;
          $display("FAIL sat_third_taken got=%b exp=1",
                   pred_taken);
        end
      end
      cycle(0, 0, 1, 1, 0);
      checks++;
      if (mispredict !== exp_misp) begin
        failures++;
        $display("FAIL sat_misp%0d got=%b exp=%b", k,
                 mispredict, exp_misp);
      end
      checks++;
      if (dut.cnt_q[5] !== want[k]) begin
        failures++;
        $display("FAIL sat_cnt%0d got=%b exp=%b", k,
                 dut.cnt_q[5], want[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(1, k, 0, 0, 0);
      checks++;
      if (obs_ready !== 1'b1 || pred_valid !== 1'b1) begin
        failures++;
        $display("FAIL fill%0d got=%b%b exp=11", k,
                 obs_ready, pred_valid);
      end
    end
    cycle(1, 9, 1, 0, 0);
    checks++;
    if (obs_ready !== 1'b0 || pred_valid !== 1'b0) begin
      failures++;
      $display("FAIL full_pop got=%b%b exp=00",
               obs_ready, pred_valid);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_ready !== 1'b1) begin
      failures++;
      $display("FAIL after_pop_ready got=%b exp=1", obs_ready);
    end
    for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 0);
    checks++;
    if (resolve_err !== 1'b0) begin
      failures++;
      $display("FAIL drain_err got=%b exp=0", resolve_err);
    end
  endtask

  task automatic test_empty_resolve();
    int bad;
    do_reset();
    cycle(0, 0, 1, 1, 0);
    checks++;
    if (resolve_err !== 1'b1 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL empty_res got=%b%b exp=10",
               resolve_err, mispredict);
    end
    repeat (3) cycle(0, 0, 0, 0, 0);
    checks++;
    if (resolve_err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b exp=1", resolve_err);
    end
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (dut.cnt_q[i] !== 2'b01) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL empty_cnt got=%0d changed exp=0", bad);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    cycle(1, 2, 0, 0, 0);
    cycle(1, 2, 1, 1, 0);
    checks++;
    if (pred_valid !== 1'b1 || pred_taken !== exp_taken) begin
      failures++;
      $display("FAIL bypass_taken got=%b%b exp=1%b",
               pred_valid, pred_taken, exp_taken);
    end
    checks++;
    if (mispredict !== 1'b1) begin
      failures++;
      $display("FAIL bypass_misp got=%b exp=1", mispredict);
    end
  endtask

  task automatic test_flush();
    do_reset();
    cycle(1, 7, 0, 0, 0);
    cycle(1, 8, 0, 0, 0);
    cycle(0, 0, 1, 1, 1);
    checks++;
    if (obs_ready !== 1'b0 || mispredict !== 1'b1) begin
      failures++;
      $display("FAIL flush_res got=%b%b exp=01",
               obs_ready, mispredict);
    end
    checks++;
    if (dut.cnt_q[7] !== 2'b10 || dut.cnt_q[8] !== 2'b01) begin
      failures++;
      $display("FAIL flush_cnt got=%b_%b exp=10_01",
               dut.cnt_q[7], dut.cnt_q[8]);
    end
    cycle(0, 0, 1, 0, 0);
    checks++;
    if (resolve_err !== 1'b1 || mispredict !== 1'b0) begin
      failures++;
      $display("FAIL flush_empty got=%b%b exp=10",
               resolve_err, mispredict);
    end
    cycle(1, 3, 0, 0, 0);
    cycle(1, 4, 1, 1, 0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({pred_valid, pred_taken, mispredict, resolve_err} !== 4'b0) begin
      failures++;
      $display("FAIL async_rst got=%b exp=0000",
               {pred_valid, pred_taken, mispredict, resolve_err});
    end
    checks++;
    if (dut.cnt_q[3] !== 2'b01 || pred_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_drop got=%b_%b exp=01_1",
               dut.cnt_q[3], pred_ready);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit req, rv, rt, fl;
    int idx;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      req = ($urandom_range(0, 99) < 60);
      rv  = ($urandom_range(0, 99) < 45);
      rt  = $urandom_range(0, 1);
      fl  = ($urandom_range(0, 99) < 4);
      idx = $urandom_range(0, 15);
      cycle(req, idx, rv, rt, fl);
      checks++;
      if (obs_ready !== exp_ready || pred_valid !== exp_valid
          || (exp_valid && pred_taken !== exp_taken)
          || mispredict !== exp_misp || resolve_err !== merr) begin
        failures++;
        $display("FAIL rand%0d got=%b%b%b%b%b exp=%b%b%b%b%b", n,
                 obs_ready, pred_valid, pred_taken, mispredict,
                 resolve_err, exp_ready, exp_valid, exp_taken,
                 exp_misp, merr);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_back_to_back();
    test_empty_resolve();
    test_bypass();
    test_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
